// File: rtl/decode_pkg.sv
// Shared constants for the decode stage.
// Holds the default field widths, the field positions within the
// instruction word and the instruction-width derivation.
package decode_pkg;

    localparam int unsigned OP_W_DEF   = 4;
    localparam int unsigned ADDR_W_DEF = 4;

    // Field positions, counted in ADDR_W-sized slots from the LSB:
    // opcode | src1 | src2 | dest
    localparam int unsigned DEST_POS = 0;
    localparam int unsigned SRC2_POS = 1;
    localparam int unsigned SRC1_POS = 2;
    localparam int unsigned OP_POS   = 3;

    function automatic int unsigned instr_width(input int unsigned op_w,
                                                input int unsigned addr_w);
        return op_w + 3 * addr_w;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Register pending scoreboard.
// Ports: clk/rst (sync, active-high); set_en/set_add marks a register
// pending; clr_en/clr_add retires a writeback; flush_en/flush_add drops
// the pending bit of a flushed instruction; chk_add1..3 are looked up
// against the post-writeback state and hazard_c reports any hit;
// pending is the registered scoreboard vector.
module reg_scoreboard
    import decode_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned ZERO_REG = 0,
    localparam int unsigned NUM_REGS = 2 ** ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [ADDR_W-1:0]   set_add,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_add,
    input  logic                flush_en,
    input  logic [ADDR_W-1:0]   flush_add,
    input  logic [ADDR_W-1:0]   chk_add1,
    input  logic [ADDR_W-1:0]   chk_add2,
    input  logic [ADDR_W-1:0]   chk_add3,
    output logic [NUM_REGS-1:0] pending,
    output logic                hazard_c
);

    logic [NUM_REGS-1:0] wb_mask;
    logic [NUM_REGS-1:0] flush_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] live;

    // Masks and the bypassed view used for the hazard lookup
    always_comb begin
        wb_mask    = '0;
        flush_mask = '0;
        set_mask   = '0;
        if (clr_en)   wb_mask[clr_add]     = 1'b1;
        if (flush_en) flush_mask[flush_add] = 1'b1;
        if (set_en)   set_mask[set_add]    = 1'b1;
        if (ZERO_REG != 0) set_mask[0] = 1'b0;
        // A writeback landing this cycle already counts as retired
        live = pending & ~wb_mask;
        if (ZERO_REG != 0) live[0] = 1'b0;
        hazard_c = live[chk_add1] | live[chk_add2] | live[chk_add3];
    end

    // Clears first, then the set, so a same-cycle set wins
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (live & ~flush_mask) | set_mask;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage with valid/ready handshake and register
// scoreboard for RAW/WAW hazard stalls.
// Ports: i_clk, i_rst (sync, active-high); i_valid/o_ready/i_instruction
// upstream; o_valid/i_ready/o_opcode/o_srcadd1/o_srcadd2/o_destadd
// downstream (registered); i_wb_valid/i_wb_add writeback retire;
// i_flush drops the held instruction; o_pending scoreboard for debug.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned OP_W     = OP_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned ZERO_REG = 0,
    localparam int unsigned INSTR_W  = instr_width(OP_W, ADDR_W),
    localparam int unsigned NUM_REGS = 2 ** ADDR_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [INSTR_W-1:0]  i_instruction,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [OP_W-1:0]     o_opcode,
    output logic [ADDR_W-1:0]   o_srcadd1,
    output logic [ADDR_W-1:0]   o_srcadd2,
    output logic [ADDR_W-1:0]   o_destadd,
    input  logic                i_wb_valid,
    input  logic [ADDR_W-1:0]   i_wb_add,
    input  logic                i_flush,
    output logic [NUM_REGS-1:0] o_pending
);

    localparam int unsigned OP_LSB   = OP_POS * ADDR_W;
    localparam int unsigned SRC1_LSB = SRC1_POS * ADDR_W;
    localparam int unsigned SRC2_LSB = SRC2_POS * ADDR_W;
    localparam int unsigned DEST_LSB = DEST_POS * ADDR_W;

    logic [OP_W-1:0]   in_op;
    logic [ADDR_W-1:0] in_src1;
    logic [ADDR_W-1:0] in_src2;
    logic [ADDR_W-1:0] in_dest;
    logic              hazard;
    logic              accept;
    logic              flush_clr;

    assign in_op   = i_instruction[OP_LSB   +: OP_W];
    assign in_src1 = i_instruction[SRC1_LSB +: ADDR_W];
    assign in_src2 = i_instruction[SRC2_LSB +: ADDR_W];
    assign in_dest = i_instruction[DEST_LSB +: ADDR_W];

    // Handshake: the output slot must be free or draining this cycle
    always_comb begin
        o_ready   = (!o_valid || i_ready) && !hazard && !i_flush && !i_rst;
        accept    = i_valid && o_ready;
        flush_clr = i_flush && o_valid;
    end

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (i_clk),
        .rst       (i_rst),
        .set_en    (accept),
        .set_add   (in_dest),
        .clr_en    (i_wb_valid),
        .clr_add   (i_wb_add),
        .flush_en  (flush_clr),
        .flush_add (o_destadd),
        .chk_add1  (in_src1),
        .chk_add2  (in_src2),
        .chk_add3  (in_dest),
        .pending   (o_pending),
        .hazard_c  (hazard)
    );

    // Output register; fields only change on accept
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid   <= 1'b0;
            o_opcode  <= '0;
            o_srcadd1 <= '0;
            o_srcadd2 <= '0;
            o_destadd <= '0;
        end else if (accept) begin
            o_valid   <= 1'b1;
            o_opcode  <= in_op;
            o_srcadd1 <= in_src1;
            o_srcadd2 <= in_src2;
            o_destadd <= in_dest;
        end else if (i_flush || i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: two instances (ZERO_REG=0 and 1)
// share one directed stimulus; a behavioural model tracks both and is
// compared every cycle, with literal expectations pinning key points.
module tb_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [15:0] instr = '0;
    logic        rdy_in = 1'b0;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_add = '0;
    logic        flush = 1'b0;

    logic [1:0]        rdy;
    logic [1:0]        ov;
    logic [1:0][3:0]   op;
    logic [1:0][3:0]   s1;
    logic [1:0][3:0]   s2;
    logic [1:0][3:0]   dd;
    logic [1:0][15:0]  pend;

    decode_stage #(.OP_W(4), .ADDR_W(4), .ZERO_REG(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy[0]),
        .i_instruction(instr), .o_valid(ov[0]), .i_ready(rdy_in),
        .o_opcode(op[0]), .o_srcadd1(s1[0]), .o_srcadd2(s2[0]),
        .o_destadd(dd[0]), .i_wb_valid(wb_valid), .i_wb_add(wb_add),
        .i_flush(flush), .o_pending(pend[0])
    );

    decode_stage #(.OP_W(4), .ADDR_W(4), .ZERO_REG(1)) dut_z (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy[1]),
        .i_instruction(instr), .o_valid(ov[1]), .i_ready(rdy_in),
        .o_opcode(op[1]), .o_srcadd1(s1[1]), .o_srcadd2(s2[1]),
        .o_destadd(dd[1]), .i_wb_valid(wb_valid), .i_wb_add(wb_add),
        .i_flush(flush), .o_pending(pend[1])
    );

    int n_pass = 0;
    int n_total = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Model: per instance, the set of pending registers and the held instruction
    logic [15:0] m_pend [2] = '{16'h0, 16'h0};
    logic        m_ov   [2] = '{1'b0, 1'b0};
    logic [15:0] m_f    [2] = '{16'h0, 16'h0};

    function automatic logic m_haz(input bit k);
        logic [15:0] busy;
        busy = m_pend[k];
        if (wb_valid) busy[wb_add] = 1'b0;
        if (k) busy[0] = 1'b0;
        return busy[instr[11:8]] | busy[instr[7:4]] | busy[instr[3:0]];
    endfunction

    function automatic logic m_rdy(input bit k);
        return !rst && (!m_ov[k] || rdy_in) && !m_haz(k) && !flush;
    endfunction

    always @(posedge clk) begin : model
        logic        acc;
        logic [15:0] np;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pend[k] = '0;
                m_ov[k]   = 1'b0;
                m_f[k]    = '0;
            end else begin
                acc = valid && m_rdy(1'(k));
                np  = m_pend[k];
                if (wb_valid) np[wb_add] = 1'b0;
                if (flush && m_ov[k]) np[m_f[k][3:0]] = 1'b0;
                if (acc && !(k == 1 && instr[3:0] == 4'd0)) np[instr[3:0]] = 1'b1;
                m_pend[k] = np;
                if (acc) begin
                    m_ov[k] = 1'b1;
                    m_f[k]  = instr;
                end else if (flush || rdy_in) begin
                    m_ov[k] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m%0d_ready", k), 32'(rdy[k]), 32'(m_rdy(1'(k))));
                chk($sformatf("m%0d_valid", k), 32'(ov[k]), 32'(m_ov[k]));
                chk($sformatf("m%0d_fields", k), 32'({op[k], s1[k], s2[k], dd[k]}), 32'(m_f[k]));
                chk($sformatf("m%0d_pending", k), 32'(pend[k]), 32'(m_pend[k]));
            end
        end
    end

    task automatic drive(input logic v, input logic [15:0] ins, input logic ir,
                         input logic wv, input logic [3:0] wa, input logic fl);
        valid = v; instr = ins; rdy_in = ir; wb_valid = wv; wb_add = wa; flush = fl;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        drive(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 1'b0);
        step();
        chk_on = 1'b1;
        neg();
        chk("rst_ready", 32'(rdy[0]), 32'd0);
        chk("rst_valid", 32'(ov[0]), 32'd0);
        chk("rst_pending", 32'(pend[0]), 32'h0);
        chk("rst_fields", 32'({op[0], s1[0], s2[0], dd[0]}), 32'h0);
        step();
        rst = 1'b0;

        // Streaming
        drive(1'b1, 16'h1234, 1'b1, 1'b0, 4'h0, 1'b0);
        neg(); chk("s1_ready", 32'(rdy[0]), 32'd1);
        step();
        drive(1'b1, 16'h2567, 1'b1, 1'b0, 4'h0, 1'b0);
        neg();
        chk("s1_valid", 32'(ov[0]), 32'd1);
        chk("s1_op", 32'(op[0]), 32'd1);
        chk("s1_src1", 32'(s1[0]), 32'd2);
        chk("s1_src2", 32'(s2[0]), 32'd3);
        chk("s1_dest", 32'(dd[0]), 32'd4);
        chk("s2_ready", 32'(rdy[0]), 32'd1);
        step();
        drive(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 1'b0);
        neg();
        chk("s2_fields", 32'({op[0], s1[0], s2[0], dd[0]}), 32'h2567);
        chk("s2_pending", 32'(pend[0]), 32'h0090);
        step();
        drive(1'b0, 16'h0, 1'b1, 1'b1, 4'h4, 1'b0); step();
        drive(1'b0, 16'h0, 1'b1, 1'b1, 4'h7, 1'b0); step();
        drive(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 1'b0);
        neg(); chk("s_retired", 32'(pend[0]), 32'h0);
        step();

        // RAW stall released by a same-cycle writeback
        drive(1'b1, 16'h1234, 1'b1, 1'b0, 4'h0, 1'b0); step();
        drive(1'b1, 16'h2456, 1'b1, 1'b0, 4'h0, 1'b0);
        neg(); chk("raw_stall0", 32'(rdy[0]), 32'd0); step();
        neg(); chk("raw_stall1", 32'(rdy[0]), 32'd0); step();
        drive(1'b1, 16'h2456, 1'b1, 1'b1, 4'h4, 1'b0);
        neg(); chk("raw_bypass", 32'(rdy[0]), 32'd1); step();
        drive(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 1'b0);
        neg();
        chk("raw_op", 32'(op[0]), 32'd2);
        chk("raw_dest", 32'(dd[0]), 32'd6);
        chk("raw_pending", 32'(pend[0]), 32'h0040);
        step();
        drive(1'b0, 16'h0, 1'b1, 1'b1, 4'h6, 1'b0); step();

        // Backpressure
        drive(1'b1, 16'h3189, 1'b0, 1'b0, 4'h0, 1'b0);
        neg(); chk("bp_first_ready", 32'(rdy[0]), 32'd1); step();
        drive(1'b1, 16'h4abc, 1'b0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("bp_valid", 32'(ov[0]), 32'd1);
            chk("bp_fields", 32'({op[0], s1[0], s2[0], dd[0]}), 32'h3189);
            chk("bp_ready", 32'(rdy[0]), 32'd0);
            step();
        end
        drive(1'b1, 16'h4abc, 1'b1, 1'b0, 4'h0, 1'b0);
        neg(); chk("bp_drain_ready", 32'(rdy[0]), 32'd1); step();
        drive(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 1'b0);
        neg();
        chk("bp_next_op", 32'(op[0]), 32'd4);
        chk("bp_pending", 32'(pend[0]), 32'h1200);
        step();
        neg(); chk("bp_empty", 32'(ov[0]), 32'd0);
        drive(1'b0, 16'h0, 1'b1, 1'b1, 4'h9, 1'b0); step();
        drive(1'b0, 16'h0, 1'b1, 1'b1, 4'hc, 1'b0); step();

        // Set/clear collision on register 5
        drive(1'b1, 16'h1005, 1'b1, 1'b0, 4'h0, 1'b0); step();
        drive(1'b1, 16'h2005, 1'b1, 1'b1, 4'h5, 1'b0);
        neg(); chk("col_ready", 32'(rdy[0]), 32'd1); step();
        drive(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 1'b0);
        neg(); chk("col_pending", 32'(pend[0]), 32'h0020); step();
        drive(1'b0, 16'h0, 1'b1, 1'b1, 4'h5, 1'b0); step();

        // Flush of held dest=7
        drive(1'b1, 16'h1237, 1'b0, 1'b0, 4'h0, 1'b0); step();
        drive(1'b1, 16'h1ab0, 1'b0, 1'b0, 4'h0, 1'b1);
        neg();
        chk("fl_ready", 32'(rdy[0]), 32'd0);
        chk("fl_held_pending", 32'(pend[0]), 32'h0080);
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        neg();
        chk("fl_valid", 32'(ov[0]), 32'd0);
        chk("fl_pending", 32'(pend[0]), 32'h0);
        step();

        // Flush coinciding with writeback
        drive(1'b1, 16'h1003, 1'b1, 1'b0, 4'h0, 1'b0); step();
        drive(1'b1, 16'h1008, 1'b1, 1'b0, 4'h0, 1'b0); step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        neg(); chk("flwb_before", 32'(pend[0]), 32'h0108); step();
        drive(1'b0, 16'h0, 1'b0, 1'b1, 4'h3, 1'b1); step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        neg();
        chk("flwb_pending", 32'(pend[0]), 32'h0);
        chk("flwb_valid", 32'(ov[0]), 32'd0);
        step();

        // Register 0 instructions: never stall with ZERO_REG=1
        drive(1'b1, 16'h1000, 1'b1, 1'b0, 4'h0, 1'b0);
        neg(); chk("z0_ready", 32'(rdy[1]), 32'd1); step();
        drive(1'b1, 16'h2000, 1'b1, 1'b0, 4'h0, 1'b0);
        neg();
        chk("z1_ready", 32'(rdy[1]), 32'd1);
        chk("z1_ready_nz", 32'(rdy[0]), 32'd0);
        step();
        drive(1'b1, 16'h3000, 1'b1, 1'b0, 4'h0, 1'b0);
        neg();
        chk("z2_ready", 32'(rdy[1]), 32'd1);
        chk("z2_pending", 32'(pend[1]), 32'h0);
        chk("z2_pending_nz", 32'(pend[0]), 32'h0001);
        step();
        drive(1'b0, 16'h0, 1'b1, 1'b1, 4'h0, 1'b0); step();
        drive(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 1'b0); step();

        // Reset during a hazard stall
        drive(1'b1, 16'h1234, 1'b1, 1'b0, 4'h0, 1'b0); step();
        drive(1'b1, 16'h2456, 1'b0, 1'b0, 4'h0, 1'b0);
        neg(); chk("rm_stall", 32'(rdy[0]), 32'd0); step();
        rst = 1'b1;
        neg(); chk("rm_rst_ready", 32'(rdy[0]), 32'd0); step();
        rst = 1'b0;
        neg();
        chk("rm_valid", 32'(ov[0]), 32'd0);
        chk("rm_pending", 32'(pend[0]), 32'h0);
        chk("rm_op", 32'(op[0]), 32'd0);
        chk("rm_ready", 32'(rdy[0]), 32'd1);
        step();
        drive(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 1'b0);
        neg();
        chk("rm_accepted", 32'({ov[0], op[0], dd[0]}), 32'h126);
        step();
        drive(1'b0, 16'h0, 1'b1, 1'b1, 4'h6, 1'b0); step();
        drive(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 1'b0); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL expose parameter OP_W, default 4, meaning opcode field width in bits.
REQ-002 The block SHALL expose parameter ADDR_W, default 4, meaning register-address field width; NUM_REGS = 2**ADDR_W.
REQ-003 The block SHALL expose parameter ZERO_REG, default 0, meaning that when 1 register 0 is never marked pending.
REQ-004 The block SHALL use derived width INSTR_W = OP_W + 3*ADDR_W, which is 16 at defaults.
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port i_valid, input, 1 bit: the upstream instruction is valid.
REQ-008 The block SHALL have port o_ready, output, 1 bit: the stage accepts the instruction this cycle.
REQ-009 The block SHALL have port i_instruction, input, INSTR_W bits: the instruction word.
REQ-010 The block SHALL have port o_valid, output, 1 bit: the decoded fields are valid.
REQ-011 The block SHALL have port i_ready, input, 1 bit: downstream accepts the decoded fields.
REQ-012 The block SHALL have ports o_opcode (OP_W), o_srcadd1, o_srcadd2 and o_destadd (ADDR_W each), all outputs: the registered decoded fields.
REQ-013 The block SHALL have ports i_wb_valid (1 bit) and i_wb_add (ADDR_W bits), both inputs: writeback retire of a register.
REQ-014 The block SHALL have port i_flush, input, 1 bit: discards the instruction held in the stage.
REQ-015 The block SHALL have port o_pending, output, NUM_REGS bits: the scoreboard contents, for debug.

Function
REQ-016 Field layout SHALL be, MSB to LSB: opcode, src1, src2, dest (bits [15:12], [11:8], [7:4], [3:0] at defaults).
REQ-017 Input accept SHALL occur when i_valid && o_ready; the fields SHALL appear on the outputs with o_valid=1 the next cycle (1-cycle latency).
REQ-018 Output handoff SHALL occur when o_valid && i_ready; while o_valid && !i_ready, all o_* fields SHALL hold stable.
REQ-019 o_ready SHALL equal (!o_valid || i_ready) && !hazard && !i_flush, so full throughput of 1 instr/cycle is possible with no bubble.
REQ-020 hazard SHALL be 1 when any of src1, src2 or dest of i_instruction is pending after applying this cycle's writeback clear (RAW and WAW protection).
REQ-021 A same-cycle i_wb_valid to a register SHALL count as cleared for the hazard check (writeback bypass).
REQ-022 On accept, pending[dest] SHALL be set; on i_wb_valid, pending[i_wb_add] SHALL be cleared.
REQ-023 If the set and the clear target the same register in the same cycle, the set SHALL win.
REQ-024 With ZERO_REG=1, register 0 SHALL never be set, SHALL never cause a hazard, and o_pending[0] SHALL be 0.
REQ-025 i_flush SHALL clear o_valid next cycle, SHALL clear pending[o_destadd] if o_valid was 1, and SHALL block accept in that cycle.
REQ-026 When flush and writeback coincide, both clears SHALL apply.
REQ-027 When o_valid=0, the field outputs SHALL hold their last value.
REQ-028 Writeback to a non-pending register SHALL have no effect.

Reset
REQ-029 On i_rst=1 at a clock edge, o_valid SHALL be 0, all o_* fields SHALL be 0, and the pending vector SHALL be all 0.
REQ-030 Reset SHALL take priority over accept, writeback and flush.
REQ-031 Reset mid-stall SHALL drop the held instruction, with no pending bit surviving.
REQ-032 o_ready SHALL be 0 while i_rst=1.

Structure
REQ-033 Package decode_pkg SHALL hold the default OP_W/ADDR_W values, the field-position offset constants, and the INSTR_W derivation function.
REQ-034 Sub-module reg_scoreboard SHALL own the pending vector, the set/clear priority and the hazard lookup for three addresses; decode_stage SHALL own the handshake and the output register.

Verification
REQ-035 The bench SHALL cover streaming: instr 0x1234 then 0x2567 with i_ready=1 -> o_opcode=1, src1=2, src2=3, dest=4 one cycle later, then the next instruction on consecutive cycles; o_ready is 0 on the second instruction only if 4 is a source or dest of it.
REQ-036 The bench SHALL cover a RAW stall: accept 0x1234, present 0x2456 -> o_ready=0 until i_wb_valid with i_wb_add=4, accepted in that same cycle.
REQ-037 The bench SHALL cover backpressure: i_ready=0 for 3 cycles with o_valid=1 -> outputs stable and o_ready=0, then drain on i_ready=1.
REQ-038 The bench SHALL cover set/clear collision: writeback to reg 5 in the same cycle as accepting dest=5 -> o_pending[5]=1 afterwards.
REQ-039 The bench SHALL cover flush: flush while holding dest=7 -> o_valid=0 and o_pending[7]=0 next cycle; with ZERO_REG=1, dest=0 instructions never stall.
REQ-040 The bench SHALL cover reset mid-stall: i_rst during a hazard stall -> o_valid=0, o_pending=0, and the first post-reset instruction is accepted immediately.
